// File: rtl/perceptron_pkg.sv
// Shared fixed-point types, limits and FSM encoding for the perceptron training path.
// Words are signed Q2.3: 1.0 = 6'sd8, range [-4.0, +3.875].
package perceptron_pkg;

    typedef logic signed [5:0] fx_t;

    localparam fx_t FX_ONE = 6'sd8;
    localparam fx_t FX_MAX = 6'sd31;
    localparam fx_t FX_MIN = fx_t'(6'b100000);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/perceptron_weight_update_if.sv
// Control, operand and weight-store port bundle for perceptron_weight_update.
// slave = the update engine; master = whoever drives it and owns the weight store.
interface perceptron_weight_update_if #(
    parameter int N_INPUTS = 4,
    parameter int WIDTH    = 6,
    parameter int AW       = $clog2(N_INPUTS + 1)
);
    logic                       start;
    logic [N_INPUTS*WIDTH-1:0]  x_in;
    logic                       target;
    logic                       y_pred;
    logic signed [WIDTH-1:0]    lr;
    logic                       clr_mistakes;
    logic signed [WIDTH-1:0]    w_rd_data;
    logic [AW-1:0]              w_addr;
    logic signed [WIDTH-1:0]    w_wr_data;
    logic                       w_wr_en;
    logic                       busy;
    logic                       done;
    logic [7:0]                 mistakes;

    modport slave (
        input  start, x_in, target, y_pred, lr, clr_mistakes, w_rd_data,
        output w_addr, w_wr_data, w_wr_en, busy, done, mistakes
    );

    modport master (
        output start, x_in, target, y_pred, lr, clr_mistakes, w_rd_data,
        input  w_addr, w_wr_data, w_wr_en, busy, done, mistakes
    );
endinterface

// File: rtl/perceptron_weight_update_fx_mul_sat.sv
// One learning-rule term: a*b, arithmetic shift right by FRAC (floor), clamp to WIDTH.
// Purely combinational.
module fx_mul_sat #(
    parameter int WIDTH = 6,
    parameter int FRAC  = 3
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y
);
    localparam logic signed [2*WIDTH-1:0] HI = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] LO = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shf;

    always_comb begin
        prod = a * b;
        shf  = prod >>> FRAC;
        if (shf > HI)      y = HI[WIDTH-1:0];
        else if (shf < LO) y = LO[WIDTH-1:0];
        else               y = shf[WIDTH-1:0];
    end
endmodule

// File: rtl/perceptron_weight_update.sv
// Perceptron learning rule: on a misclassification, rewrites every weight once per cycle.
// PERCEPTRON_BIAS_EN adds one extra pass step at index N_INPUTS with x = 1.0.
module perceptron_weight_update
    import perceptron_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int WIDTH    = 6,
    parameter int FRAC     = 3
) (
    input  logic                        clk,
    input  logic                        reset_l,
    perceptron_weight_update_if.slave   wif
);
    localparam int AW = $clog2(N_INPUTS + 1);
`ifdef PERCEPTRON_BIAS_EN
    localparam int W_CNT = N_INPUTS + 1;
`else
    localparam int W_CNT = N_INPUTS;
`endif
    localparam logic [AW-1:0] LAST = AW'(W_CNT - 1);
    localparam logic signed [WIDTH:0] SUM_HI = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] SUM_LO = {2'b11, {(WIDTH-1){1'b0}}};

    state_t                    state_q, state_d;
    logic [N_INPUTS*WIDTH-1:0] x_q, x_d;
    logic                      tgt_q, tgt_d;
    logic                      ypred_q, ypred_d;
    logic signed [WIDTH-1:0]   lr_q, lr_d;
    logic [AW-1:0]             idx_q, idx_d;
    logic [7:0]                mistakes_q, mistakes_d;

    logic signed [WIDTH-1:0]   x_sel;
    logic signed [WIDTH-1:0]   delta;
    logic signed [WIDTH:0]     w_ext, d_ext, sum;
    logic signed [WIDTH-1:0]   sum_sat;
    logic                      err;

    assign err = (tgt_q != ypred_q);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        tgt_d   = tgt_q;
        ypred_d = ypred_q;
        lr_d    = lr_q;
        case (state_q)
            IDLE: begin
                if (wif.start) begin
                    state_d = CHECK;
                    x_d     = wif.x_in;
                    tgt_d   = wif.target;
                    ypred_d = wif.y_pred;
                    lr_d    = wif.lr;
                end
            end
            CHECK:   state_d = err ? UPDATE : DONE;
            UPDATE:  if (idx_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            x_q     <= '0;
            tgt_q   <= 1'b0;
            ypred_q <= 1'b0;
            lr_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            tgt_q   <= tgt_d;
            ypred_q <= ypred_d;
            lr_q    <= lr_d;
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (state_q == CHECK)       idx_d = '0;
        else if (state_q == UPDATE) idx_d = idx_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) idx_q <= '0;
        else          idx_q <= idx_d;
    end

    // Clear wins over a same-cycle increment.
    always_comb begin
        mistakes_d = mistakes_q;
        if (wif.clr_mistakes)
            mistakes_d = '0;
        else if (state_q == CHECK && err && mistakes_q != 8'hFF)
            mistakes_d = mistakes_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) mistakes_q <= '0;
        else          mistakes_q <= mistakes_d;
    end

    always_comb begin
        x_sel = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (idx_q == AW'(i)) x_sel = x_q[i*WIDTH +: WIDTH];
        end
`ifdef PERCEPTRON_BIAS_EN
        if (idx_q == AW'(N_INPUTS)) x_sel = WIDTH'(FX_ONE);
`endif
    end

    fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
        .a (lr_q),
        .b (x_sel),
        .y (delta)
    );

    // Sign of the error selects add or subtract; one guard bit makes it overflow-free.
    always_comb begin
        w_ext = {wif.w_rd_data[WIDTH-1], wif.w_rd_data};
        d_ext = {delta[WIDTH-1], delta};
        sum   = tgt_q ? (w_ext + d_ext) : (w_ext - d_ext);
        if (sum > SUM_HI)      sum_sat = SUM_HI[WIDTH-1:0];
        else if (sum < SUM_LO) sum_sat = SUM_LO[WIDTH-1:0];
        else                   sum_sat = sum[WIDTH-1:0];
    end

    always_comb begin
        wif.w_wr_en   = (state_q == UPDATE);
        wif.w_addr    = wif.w_wr_en ? idx_q : '0;
        wif.w_wr_data = wif.w_wr_en ? sum_sat : '0;
        wif.busy      = (state_q != IDLE);
        wif.done      = (state_q == DONE);
        wif.mistakes  = mistakes_q;
    end
endmodule

// File: tb/tb_perceptron_weight_update.sv
// Directed bench for perceptron_weight_update with a behavioural weight store.
// Build with +define+PERCEPTRON_BIAS_EN to exercise the bias step.
module tb_perceptron_weight_update;
    import perceptron_pkg::*;

    localparam int N  = 4;
    localparam int WD = 6;
`ifdef PERCEPTRON_BIAS_EN
    localparam int W = N + 1;
`else
    localparam int W = N;
`endif

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    always #5 clk = ~clk;

    perceptron_weight_update_if #(.N_INPUTS(N), .WIDTH(WD)) wif ();

    perceptron_weight_update #(.N_INPUTS(N), .WIDTH(WD), .FRAC(3)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .wif     (wif.slave)
    );

    logic signed [5:0] wmem   [0:7];
    logic signed [5:0] preset [0:7];
    logic              load = 1'b0;

    always @(posedge clk) begin
        if (load)             wmem <= preset;
        else if (wif.w_wr_en) wmem[wif.w_addr] <= wif.w_wr_data;
    end
    assign wif.w_rd_data = wmem[wif.w_addr];

    int n_cmp = 0;
    int n_bad = 0;
    int max_addr = 0;
    int busy_bad;
    int wr_a[$];
    int wr_d[$];
    int dn;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_w(input int w0, input int w1, input int w2, input int w3, input int w4);
        @(negedge clk);
        for (int i = 0; i < 8; i++) preset[i] = '0;
        preset[0] = 6'(w0); preset[1] = 6'(w1); preset[2] = 6'(w2);
        preset[3] = 6'(w3); preset[4] = 6'(w4);
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    // Returns the cycle (counted from the start edge) in which done was seen, -1 on timeout.
    task automatic run_pass(input logic [23:0] x, input logic tgt, input logic yp,
                            input logic [5:0] l, input logic clr, output int done_at);
        @(negedge clk);
        wif.start = 1'b1; wif.x_in = x; wif.target = tgt; wif.y_pred = yp;
        wif.lr = l; wif.clr_mistakes = clr;
        @(posedge clk);
        #1;
        wif.start = 1'b0; wif.x_in = '1; wif.target = ~tgt; wif.y_pred = ~yp; wif.lr = 6'sd31;
        wr_a.delete(); wr_d.delete();
        busy_bad = 0;
        done_at = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (!wif.busy) busy_bad++;
            if (wif.w_wr_en) begin
                wr_a.push_back(int'(wif.w_addr));
                wr_d.push_back(int'(wif.w_wr_data));
                if (int'(wif.w_addr) > max_addr) max_addr = int'(wif.w_addr);
            end
            if (wif.done) begin
                done_at = c;
                break;
            end
        end
        wif.clr_mistakes = 1'b0;
    endtask

    initial begin
        wif.start = 0; wif.x_in = '0; wif.target = 0; wif.y_pred = 0;
        wif.lr = '0; wif.clr_mistakes = 0;
        for (int i = 0; i < 8; i++) preset[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", wif.busy, 0);
        chk("rst_done", wif.done, 0);
        chk("rst_wr_en", wif.w_wr_en, 0);
        chk("rst_addr", wif.w_addr, 0);
        chk("rst_wdata", wif.w_wr_data, 0);
        chk("rst_mistakes", wif.mistakes, 0);
        @(negedge clk) reset_l = 1'b1;

        // lr=0.5, x=1.0 everywhere: every weight (bias included) gains 0.5.
        load_w(0, 0, 0, 0, 0);
        run_pass({4{6'sd8}}, 1'b1, 1'b0, 6'sd4, 1'b0, dn);
        chk("t1_done_cycle", dn, 2 + W);
        chk("t1_nwrites", wr_a.size(), W);
        for (int i = 0; i < wr_a.size(); i++) begin
            chk($sformatf("t1_addr%0d", i), wr_a[i], i);
            chk($sformatf("t1_data%0d", i), wr_d[i], 4);
        end
        chk("t1_busy", busy_bad, 0);
        chk("t1_mistakes", wif.mistakes, 1);
        @(negedge clk);
        chk("t1_idle_busy", wif.busy, 0);

        // Correct prediction: no writes, done two cycles after start.
        run_pass({4{6'sd8}}, 1'b1, 1'b1, 6'sd4, 1'b0, dn);
        chk("t2_done_cycle", dn, 2);
        chk("t2_nwrites", wr_a.size(), 0);
        chk("t2_mistakes", wif.mistakes, 1);

        // e=-1, lr=1.0: w0 -20-31 clamps to -32; w1 0-(-8) = 8; x=0 leaves w2,w3.
        load_w(-20, 0, 5, -3, 0);
        run_pass({6'sd0, 6'sd0, 6'b111000, 6'sd31}, 1'b0, 1'b1, 6'sd8, 1'b0, dn);
        chk("t3_done_cycle", dn, 2 + W);
        chk("t3_w0", wmem[0], -32);
        chk("t3_w1", wmem[1], 8);
        chk("t3_w2", wmem[2], 5);
        chk("t3_w3", wmem[3], -3);
`ifdef PERCEPTRON_BIAS_EN
        chk("t3_bias", wmem[4], -8);
`endif
        chk("t3_mistakes", wif.mistakes, 2);

        // lr=31: product clamp high/low, floor of -31/8 = -4, and 31/8 = 3.
        load_w(20, 10, 0, 0, 0);
        run_pass({6'sd1, 6'b111111, 6'b100000, 6'sd31}, 1'b1, 1'b0, 6'sd31, 1'b0, dn);
        chk("t4_w0", wmem[0], 31);
        chk("t4_w1", wmem[1], -22);
        chk("t4_w2", wmem[2], -4);
        chk("t4_w3", wmem[3], 3);
`ifdef PERCEPTRON_BIAS_EN
        chk("t4_bias", wmem[4], 31);
`endif
        chk("t4_mistakes", wif.mistakes, 3);

        // Mistake counter saturation, then clear racing an increment.
        for (int k = 0; k < 252; k++) run_pass(24'h0, 1'b1, 1'b0, 6'sd0, 1'b0, dn);
        chk("t5_mistakes_255", wif.mistakes, 255);
        run_pass(24'h0, 1'b0, 1'b1, 6'sd0, 1'b0, dn);
        chk("t5_mistakes_sat", wif.mistakes, 255);
        run_pass(24'h0, 1'b0, 1'b1, 6'sd0, 1'b1, dn);
        chk("t5_mistakes_clr", wif.mistakes, 0);

        // Reset in the second UPDATE cycle: only w0 has been committed.
        load_w(1, 2, 3, 4, 0);
        @(negedge clk);
        wif.start = 1'b1; wif.x_in = {4{6'sd8}}; wif.target = 1'b1; wif.y_pred = 1'b0;
        wif.lr = 6'sd4;
        @(posedge clk);
        #1 wif.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_addr_before_rst", wif.w_addr, 1);
        reset_l = 1'b0;
        #1;
        chk("t6_busy", wif.busy, 0);
        chk("t6_done", wif.done, 0);
        chk("t6_wr_en", wif.w_wr_en, 0);
        chk("t6_addr", wif.w_addr, 0);
        chk("t6_wdata", wif.w_wr_data, 0);
        chk("t6_mistakes", wif.mistakes, 0);
        @(negedge clk) reset_l = 1'b1;
        chk("t6_w0", wmem[0], 5);
        chk("t6_w1", wmem[1], 2);
        chk("t6_w2", wmem[2], 3);
        chk("t6_w3", wmem[3], 4);
        run_pass({4{6'sd8}}, 1'b1, 1'b1, 6'sd4, 1'b0, dn);
        chk("t6_recover_done", dn, 2);

`ifdef PERCEPTRON_BIAS_EN
        // Only the bias term is non-zero: x=0 for inputs, x=1.0 for the bias.
        load_w(0, 0, 0, 0, 0);
        run_pass(24'h0, 1'b1, 1'b0, 6'sd8, 1'b0, dn);
        chk("t7_done_cycle", dn, 7);
        chk("t7_nwrites", wr_a.size(), 5);
        if (wr_a.size() == 5) begin
            chk("t7_bias_addr", wr_a[4], 4);
            chk("t7_bias_data", wr_d[4], 8);
        end
        chk("t7_bias_mem", wmem[4], 8);
`else
        chk("t7_max_addr", max_addr, N - 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/perceptron_weight_update.md
# perceptron_weight_update

Training-direction counterpart to the perceptron's forward datapath: after each classification, compares the predicted output against the target and, on a mistake, rewrites every weight in the shared weight register file with the perceptron learning rule w[i] <= w[i] + e*lr*x[i]. It sits beside the forward inference engine and is the only writer of the weight store. It sequences one weight per cycle using a small FSM and an index counter. It keeps a saturating mistake counter for convergence monitoring.

## Interface
- N_INPUTS, default 4: number of input/weight pairs, not counting the bias.
- WIDTH, default 6: fixed-point word width.
- FRAC, default 3: fractional bits. Format is signed two's complement Q2.3; 1.0 = 6'sd8.
- clk  in  1  clock
- reset_l  in  1  reset, asynchronous, active-low
- start  in  1  request an update pass; sampled only in IDLE
- x_in  in  N_INPUTS*WIDTH  packed input vector; x_in[i] occupies bits [i*WIDTH +: WIDTH]
- target  in  1  desired class, 0 or 1
- y_pred  in  1  forward-pass output, 0 or 1
- lr  in  WIDTH  learning rate, signed Q2.3
- w_rd_data  in  WIDTH  weight at w_addr, read combinationally from the store
- w_addr  out  $clog2(N_INPUTS+1)  weight index
- w_wr_data  out  WIDTH  updated weight
- w_wr_en  out  1  weight write strobe; the store commits on the same clk edge
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse at the end of a pass
- mistakes  out  8  saturating count of passes in which an error was detected
- clr_mistakes  in  1  synchronous clear of the mistake counter

## Operation
- Reset values: all outputs are 0. State is IDLE. Latched operands are 0.
- IDLE:
  - start=1 latches x_in, target, y_pred and lr, then moves to CHECK.
  - start in any other state is ignored.
- CHECK (1 cycle):
  - If target==y_pred, go to DONE. No writes occur.
  - Otherwise, increment mistakes (saturates at 255), clear the index, and go to UPDATE.
- UPDATE (one cycle per weight):
  - w_addr = index and w_wr_en = 1.
  - w_wr_data = sat(w_rd_data + e*delta[index]), where e = +1 if target=1 and −1 if target=0.
  - After the last index, go to DONE.
- DONE (1 cycle): done=1, then go to IDLE.
- Arithmetic:
  - delta = the 12-bit signed product lr*x, arithmetic shift right by FRAC (floor), saturated to the range [-32, 31].
  - The sum is formed at WIDTH+1 bits and saturated to [-32, 31].
- clr_mistakes has priority over the increment in the same cycle.
- A reset during UPDATE returns the block to IDLE immediately. Weights already written stay written; no rollback.

## Timing
- start is sampled at edge t.
- CHECK occurs in cycle t+1.
- Error case:
  - UPDATE occupies cycles t+2 .. t+1+W.
  - done is high in cycle t+2+W.
  - W = N_INPUTS, or N_INPUTS+1 with the bias enabled.
- No-error case: done is high in cycle t+2.
- busy is high from cycle t+1 through the done cycle inclusive.
- A new start is accepted no earlier than the cycle after done.
- Inputs may change freely after the start edge, because they are latched.

## Configuration
- PERCEPTRON_BIAS_EN
  - Defined: one extra UPDATE cycle at index N_INPUTS, using x = 1.0 (6'sd8), so the bias weight is trained.
  - Undefined: exactly N_INPUTS UPDATE cycles; w_addr never reaches N_INPUTS.

## Structure
- perceptron_pkg holds:
  - typedef fx_t (logic signed [5:0]);
  - FX_ONE, FX_MAX and FX_MIN;
  - the FSM state enum {IDLE, CHECK, UPDATE, DONE}.
- Sub-module fx_mul_sat performs the signed multiply, shift and saturate for one term. It is instantiated once and reused each cycle.
- The index and mistake counter are local always_ff blocks.

## Test plan
- Target=1, y=0, lr=4 (0.5), all x=8, all w=0 → 4 writes of 4; done at t+6; mistakes=1.
- Target=y=1 → no w_wr_en; done at t+2; mistakes unchanged.
- Target=0, y=1, lr=8, x0=31, w0=-20 → w0 written -32 (saturated); x1=-8, w1=0 → w1=8.
- mistakes at 255 plus another error → stays 255; clr_mistakes together with an error → 0.
- Assert reset_l low in the 2nd UPDATE cycle → all outputs 0 and IDLE; w0 is updated, w1..w3 are untouched.
- PERCEPTRON_BIAS_EN defined, lr=8, target=1, y=0, bias w=0 → w_addr=4 written 8; done at t+7.
